// File: rtl/disp_pkg.sv
// Shared state, pattern-select and step-count definitions for the display controller.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_ANIM = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_SPIN  = 2'd0,
        SEL_FILL  = 2'd1,
        SEL_CHASE = 2'd2,
        SEL_FLASH = 2'd3
    } anim_sel_t;

    localparam logic [3:0] SPIN_STEPS  = 4'd6;
    localparam logic [3:0] FILL_STEPS  = 4'd6;
    localparam logic [3:0] CHASE_STEPS = 4'd8;
    localparam logic [3:0] FLASH_STEPS = 4'd2;

    function automatic logic [2:0] last_step(input anim_sel_t sel);
        logic [3:0] n;
        n = SPIN_STEPS;
        case (sel)
            SEL_SPIN:  n = SPIN_STEPS;
            SEL_FILL:  n = FILL_STEPS;
            SEL_CHASE: n = CHASE_STEPS;
            SEL_FLASH: n = FLASH_STEPS;
            default:   n = SPIN_STEPS;
        endcase
        return 3'(n - 4'd1);
    endfunction

    // Segment order: bit0 top .. bit5 upper-left, bit6 middle, bit7 dp.
    function automatic logic [7:0] pattern(input anim_sel_t sel, input logic [2:0] step);
        logic [7:0] p;
        p = 8'h00;
        case (sel)
            SEL_SPIN:  p = 8'h01 << step;
            SEL_FILL:  p = 8'((9'h002 << step) - 9'd1);
            SEL_CHASE: p = 8'h01 << step;
            SEL_FLASH: p = (step == 3'd0) ? 8'hFF : 8'h00;
            default:   p = 8'h00;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/disp_ctrl_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks; clear restarts the period.
module tick_gen #(
    parameter logic [15:0] TICK_DIV = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    logic [15:0] cnt;

    assign tick = (cnt == TICK_DIV - 16'd1);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= 16'd0;
        end else if (tick) begin
            cnt <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end
endmodule

// File: rtl/disp_ctrl.sv
// Seven-segment display sequencer: static digit, blinking digit, or canned animations.
// state | meaning
// IDLE  | display blanked, waiting for a write or animation start
// SHOW  | latched digit shown, optionally blinking on each tick
// ANIM  | raw segment pattern stepped on each tick for ANIM_LOOPS passes
module disp_ctrl
    import disp_pkg::*;
#(
    parameter logic [15:0] TICK_DIV   = 16'd50000,
    parameter int          ANIM_LOOPS = 2
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       disp_wr_in,
    input  logic [4:0] disp_data_in,
    input  logic       disp_clr_in,
    input  logic       anim_start_in,
    input  logic [1:0] anim_sel_in,
    input  logic       blink_en_in,
    output logic [4:0] value_out,
    output logic [7:0] bit_array_out,
    output logic       anim_en_out,
    output logic       display_on_out,
    output logic       busy_out
);
    localparam logic [3:0] LAST_LOOP = 4'(ANIM_LOOPS - 1);

    state_t     state;
    anim_sel_t  sel_q;
    logic [2:0] step;
    logic [3:0] loop;
    logic       written;
    logic       tick;
    logic [2:0] step_nxt;

    assign step_nxt = step + 3'd1;

    // A clear outranks a start, so the prescaler only restarts for an accepted start.
    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .clear (anim_start_in & ~disp_clr_in),
        .tick  (tick)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n_in || disp_clr_in) begin
            state          <= ST_IDLE;
            sel_q          <= SEL_SPIN;
            step           <= 3'd0;
            loop           <= 4'd0;
            written        <= 1'b0;
            value_out      <= 5'd0;
            bit_array_out  <= 8'd0;
            anim_en_out    <= 1'b0;
            display_on_out <= 1'b0;
            busy_out       <= 1'b0;
        end else begin
            if (disp_wr_in) begin
                value_out <= disp_data_in;
                written   <= 1'b1;
            end
            if (anim_start_in) begin
                state          <= ST_ANIM;
                sel_q          <= anim_sel_t'(anim_sel_in);
                step           <= 3'd0;
                loop           <= 4'd0;
                bit_array_out  <= pattern(anim_sel_t'(anim_sel_in), 3'd0);
                anim_en_out    <= 1'b1;
                busy_out       <= 1'b1;
                display_on_out <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        anim_en_out <= 1'b0;
                        if (disp_wr_in) begin
                            state          <= ST_SHOW;
                            display_on_out <= 1'b1;
                        end else begin
                            display_on_out <= 1'b0;
                        end
                    end
                    ST_SHOW: begin
                        if (!blink_en_in) begin
                            display_on_out <= 1'b1;
                        end else if (tick) begin
                            display_on_out <= ~display_on_out;
                        end
                    end
                    ST_ANIM: begin
                        if (tick) begin
                            if (step == last_step(sel_q)) begin
                                step <= 3'd0;
                                if (loop == LAST_LOOP) begin
                                    anim_en_out   <= 1'b0;
                                    busy_out      <= 1'b0;
                                    bit_array_out <= 8'd0;
                                    if (written || disp_wr_in) begin
                                        state          <= ST_SHOW;
                                        display_on_out <= 1'b1;
                                    end else begin
                                        state          <= ST_IDLE;
                                        display_on_out <= 1'b0;
                                    end
                                end else begin
                                    loop          <= loop + 4'd1;
                                    bit_array_out <= pattern(sel_q, 3'd0);
                                end
                            end else begin
                                step          <= step_nxt;
                                bit_array_out <= pattern(sel_q, step_nxt);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_disp_ctrl.sv
// Scoreboard bench for disp_ctrl with TICK_DIV=4, ANIM_LOOPS=2.
module tb_disp_ctrl;
    logic       clk;
    logic       rst_n;
    logic       disp_wr;
    logic [4:0] disp_data;
    logic       disp_clr;
    logic       anim_start;
    logic [1:0] anim_sel;
    logic       blink_en;
    logic [4:0] value;
    logic [7:0] bit_array;
    logic       anim_en;
    logic       display_on;
    logic       busy;

    disp_ctrl #(.TICK_DIV(16'd4), .ANIM_LOOPS(2)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .disp_wr_in     (disp_wr),
        .disp_data_in   (disp_data),
        .disp_clr_in    (disp_clr),
        .anim_start_in  (anim_start),
        .anim_sel_in    (anim_sel),
        .blink_en_in    (blink_en),
        .value_out      (value),
        .bit_array_out  (bit_array),
        .anim_en_out    (anim_en),
        .display_on_out (display_on),
        .busy_out       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      name;
        logic [4:0] val;
        logic [7:0] bits;
        logic       anim;
        logic       disp;
        logic       bsy;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] spin_t  [0:5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    logic [7:0] fill_t  [0:5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F};
    logic [7:0] chase_t [0:7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] flash_t [0:1] = '{8'hFF, 8'h00};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int dc, input string nm, input logic [4:0] v, input logic [7:0] b,
                        input logic a, input logic d, input logic bz);
        exp_t e;
        e.cyc = cyc + dc; e.name = nm; e.val = v; e.bits = b;
        e.anim = a; e.disp = d; e.bsy = bz;
        q.push_back(e);
    endtask

    // Monitor: compares the head entry when its cycle comes up, away from the rising edge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            cur = q.pop_front();
            checks++; errors++;
            $display("FAIL %s cyc=%0d: check missed (now cyc=%0d)", cur.name, cur.cyc, cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            cur = q.pop_front();
            checks++;
            if (value !== cur.val || bit_array !== cur.bits || anim_en !== cur.anim ||
                display_on !== cur.disp || busy !== cur.bsy) begin
                errors++;
                $display("FAIL %s cyc=%0d: got val=%h bits=%h anim=%b disp=%b busy=%b, exp val=%h bits=%h anim=%b disp=%b busy=%b",
                         cur.name, cyc, value, bit_array, anim_en, display_on, busy,
                         cur.val, cur.bits, cur.anim, cur.disp, cur.bsy);
            end
        end
    end

    initial begin
        int wait_cnt;
        rst_n = 1'b0; disp_wr = 1'b0; disp_data = 5'd0; disp_clr = 1'b0;
        anim_start = 1'b0; anim_sel = 2'd0; blink_en = 1'b0;

        // reset, then a write moves IDLE to SHOW
        push(2, "reset", 5'h00, 8'h00, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(1, "idle_after_rst", 5'h00, 8'h00, 0, 0, 0);
        @(negedge clk);
        disp_wr = 1'b1; disp_data = 5'h1A;
        push(1, "wr_show", 5'h1A, 8'h00, 0, 1, 0);
        push(2, "show_steady", 5'h1A, 8'h00, 0, 1, 0);
        push(3, "show_steady", 5'h1A, 8'h00, 0, 1, 0);
        @(negedge clk);
        disp_wr = 1'b0;
        repeat (2) @(negedge clk);

        // spin x2 (48 clocks), then SHOW with blink toggling every 4, then blink off
        anim_start = 1'b1; anim_sel = 2'd0; blink_en = 1'b1;
        for (int k = 1; k <= 48; k++)
            push(k, "spin", 5'h1A, spin_t[((k - 1) / 4) % 6], 1, 1, 1);
        for (int k = 49; k <= 60; k++)
            push(k, "blink", 5'h1A, 8'h00, 0, (((k - 49) / 4) % 2) == 0, 0);
        for (int k = 61; k <= 64; k++)
            push(k, "blink_off", 5'h1A, 8'h00, 0, 1, 0);
        @(negedge clk);
        anim_start = 1'b0;
        repeat (59) @(negedge clk);
        blink_en = 1'b0;
        repeat (4) @(negedge clk);

        // chase with a write mid-animation, restarted as flash at step 3 of the second loop
        anim_start = 1'b1; anim_sel = 2'd2;
        for (int k = 1; k <= 45; k++)
            push(k, "chase", (k >= 21) ? 5'h05 : 5'h1A, chase_t[((k - 1) / 4) % 8], 1, 1, 1);
        for (int j = 1; j <= 16; j++)
            push(45 + j, "flash_restart", 5'h05, flash_t[((j - 1) / 4) % 2], 1, 1, 1);
        push(62, "flash_exit_show", 5'h05, 8'h00, 0, 1, 0);
        @(negedge clk);
        anim_start = 1'b0;
        repeat (19) @(negedge clk);
        disp_wr = 1'b1; disp_data = 5'h05;
        @(negedge clk);
        disp_wr = 1'b0;
        repeat (24) @(negedge clk);
        anim_start = 1'b1; anim_sel = 2'd3;
        @(negedge clk);
        anim_start = 1'b0;
        repeat (16) @(negedge clk);

        // fill, then clr coincident with start+wr; a later animation ends in IDLE
        anim_start = 1'b1; anim_sel = 2'd1;
        for (int k = 1; k <= 6; k++)
            push(k, "fill", 5'h05, fill_t[(k - 1) / 4], 1, 1, 1);
        push(7, "clr_priority", 5'h00, 8'h00, 0, 0, 0);
        @(negedge clk);
        anim_start = 1'b0;
        repeat (5) @(negedge clk);
        anim_start = 1'b1; anim_sel = 2'd0; disp_clr = 1'b1; disp_wr = 1'b1; disp_data = 5'h1F;
        @(negedge clk);
        anim_start = 1'b0; disp_clr = 1'b0; disp_wr = 1'b0;
        push(1, "idle_after_clr", 5'h00, 8'h00, 0, 0, 0);
        repeat (2) @(negedge clk);
        anim_start = 1'b1; anim_sel = 2'd3;
        for (int j = 1; j <= 16; j++)
            push(j, "flash_noval", 5'h00, flash_t[((j - 1) / 4) % 2], 1, 1, 1);
        push(17, "exit_idle", 5'h00, 8'h00, 0, 0, 0);
        push(18, "idle_hold", 5'h00, 8'h00, 0, 0, 0);
        @(negedge clk);
        anim_start = 1'b0;
        repeat (17) @(negedge clk);

        // wr+start together, then reset mid-animation
        disp_wr = 1'b1; disp_data = 5'h13; anim_start = 1'b1; anim_sel = 2'd0;
        for (int k = 1; k <= 6; k++)
            push(k, "wr_and_start", 5'h13, spin_t[(k - 1) / 4], 1, 1, 1);
        push(7, "rst_abort", 5'h00, 8'h00, 0, 0, 0);
        @(negedge clk);
        disp_wr = 1'b0; anim_start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push(1, "idle_after_abort", 5'h00, 8'h00, 0, 0, 0);
        repeat (3) @(negedge clk);

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 200) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d expected entries never checked", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
